// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared definitions for the unified-memory port arbiter:
//   - arb_state_t : sequencing FSM encoding (IDLE / BUSY / DONE)
//   - owner_t     : which pipeline stage owns the current transaction
//   - next_owner(): fixed-priority pick between the two requesters
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Data memory always wins a collision. Fetch can be starved, which is
  // harmless: while DM stalls, the front of the pipe is frozen anyway.
  // Only meaningful when at least one request is present.
  function automatic owner_t next_owner(input logic dm_req);
    return dm_req ? OWN_DM : OWN_IF;
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// ---------------------------------------------------------------------------
// timeout_counter
//
// Counts the cycles a memory transaction has spent waiting for its ack.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset, zeroes the count
//   clear  in   synchronous clear (has priority over enable)
//   enable in   count this cycle
//   tc     out  combinational: this enabled cycle is the TIMEOUT-th one
//
// The count holds the number of enabled cycles already elapsed, so tc is
// raised during the TIMEOUT-th enabled cycle itself; the owner of the counter
// can then leave its waiting state on that same edge.
// ---------------------------------------------------------------------------
module timeout_counter #(
  parameter int TIMEOUT = 15,
  parameter int W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      // Saturate at LAST; the FSM leaves BUSY on tc so this is only a guard.
      count <= count + W'(1);
    end
  end

  assign tc = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port instruction/data memory between the fetch stage (IF)
// and the memory stage (DM). One transaction at a time, DM has strict
// priority, every transaction is bounded by a timeout.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   if_req/if_addr        fetch request (level, held until if_valid)
//   if_rdata/if_valid     fetched word (held) and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request (level, held until dm_valid)
//   dm_rdata/dm_valid     load data (held) and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack     memory read data and one-cycle completion
//   stall_if/stall_dm     combinational stall = req & ~valid
//   err                   one-cycle pulse with valid when the access timed out
//   busy                  FSM is not IDLE
//
// Handshake: a requester raises req and holds it, with its address/data
// stable, until it sees its valid pulse; valid is high for exactly one cycle
// and rdata is already updated in that cycle. On the memory side mem_req and
// the address/data stay stable until mem_ack is seen for one cycle; an ack
// outside BUSY carries no meaning and is ignored.
//
// Cycle sequence for the shortest access:
//   cycle 0 IDLE (grant), cycle 1 BUSY (mem_req, ack), cycle 2 DONE (valid),
//   cycle 3 IDLE again.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              err,
  output logic              busy
);

  arb_state_t state;
  owner_t     owner;
  logic       timed_out;

  // The wait counter runs only while a request is outstanding and restarts
  // from zero for every transaction.
  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_BUSY),
    .enable (state == ST_BUSY),
    .tc     (timed_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Completion flags are pulses: default low, set only on the edge that
      // enters DONE.
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      err      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (dm_req || if_req) begin
            owner   <= next_owner(dm_req);
            mem_req <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_BUSY;
            if (dm_req) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              // Fetches are always reads; zero the unused write data so the
              // bus does not carry stale store data.
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end

        ST_BUSY: begin
          // Ack takes precedence over a timeout landing on the same cycle.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_DONE;
            if (owner == OWN_DM) begin
              dm_valid <= 1'b1;
              // A store returns nothing; keep the last load result.
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (timed_out) begin
            // Give up: report the error, leave read data untouched.
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b1;
            state   <= ST_DONE;
            if (owner == OWN_DM) begin
              dm_valid <= 1'b1;
            end else begin
              if_valid <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          // No arbitration here: a requester sees its valid this cycle and
          // may still be holding req, which must not win a second grant.
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall_if = if_req & ~if_valid;
  assign stall_dm = dm_req & ~dm_valid;

endmodule
